// File: rtl/vote_bus_arbiter_if.sv
// Voter bus: per-node request lines and vote words from the nodes,
// one-hot grant back from the arbiter.
//   req    [NUM_NODES]    node -> arbiter, held high for a whole transaction
//   node_v [4*NUM_NODES]  node -> arbiter, {parity, red, green, key} per node
//   gnt    [NUM_NODES]    arbiter -> node, one-hot or zero
interface vote_bus_arbiter_if #(
   parameter int NUM_NODES = 4
);
   logic [NUM_NODES-1:0]   req;
   logic [4*NUM_NODES-1:0] node_v;
   logic [NUM_NODES-1:0]   gnt;

   modport master (output req, output node_v, input gnt);
   modport slave  (input req, input node_v, output gnt);
endinterface

// File: rtl/vote_bus_arbiter.sv
// Round-robin arbiter sharing one tally unit among NUM_NODES voter nodes.
// Each transaction is a 4-phase req/gnt handshake. The granted node's vote
// word is parity-checked and counted into saturating tallies. The poll
// can be closed from IDLE. Once closed it stays closed until reset.
//   clock       system clock, rising edge
//   reset       synchronous, active high
//   bus         vote_bus_arbiter_if.slave (req, node_v in; gnt out)
//   close_poll  close request, sampled only in IDLE
//   busy        transaction in flight (GRANT or WAIT_REL)
//   closed      poll closed
//   done        one-cycle pulse on entry to CLOSED
//   green_cnt / red_cnt  valid votes with green / red set
//   blank_cnt   parity-good words with key clear
//   err_cnt     words with a parity error
//
// state      | meaning
// S_IDLE     | no owner, choose next requester round-robin from ptr
// S_GRANT    | one cycle, tally the captured vote
// S_WAIT_REL | hold gnt until the owner drops req
// S_CLOSED   | poll closed, terminal until reset
module vote_bus_arbiter #(
   parameter int NUM_NODES = 4,
   parameter int COUNT_W   = 8
) (
   input  logic               clock,
   input  logic               reset,
   vote_bus_arbiter_if.slave  bus,
   input  logic               close_poll,
   output logic               busy,
   output logic               closed,
   output logic               done,
   output logic [COUNT_W-1:0] green_cnt,
   output logic [COUNT_W-1:0] red_cnt,
   output logic [COUNT_W-1:0] blank_cnt,
   output logic [COUNT_W-1:0] err_cnt
);
   localparam int PTR_W = $clog2(NUM_NODES);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT_REL, S_CLOSED} state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [PTR_W-1:0]     owner_q, owner_d;
   logic [3:0]           vote_q, vote_d;
   logic [NUM_NODES-1:0] gnt_q, gnt_d;
   logic                 done_q, done_d;
   logic                 tally_en;
   logic                 parity_bad;
   logic [PTR_W-1:0]     winner;
   logic                 found;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Scan from ptr downward in priority. The last hit is the one nearest ptr.
   always_comb begin : win_search
      int               idx;
      logic [PTR_W-1:0] idx_w;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      idx_w  = '0;
      for (int k = NUM_NODES - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_NODES) idx = idx - NUM_NODES;
         idx_w = PTR_W'(idx);
         if (bus.req[idx_w]) begin
            winner = idx_w;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      vote_d   = vote_q;
      gnt_d    = gnt_q;
      done_d   = 1'b0;
      tally_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (close_poll) begin
               state_d = S_CLOSED;
               done_d  = 1'b1;
               gnt_d   = '0;
            end else if (found) begin
               owner_d        = winner;
               vote_d         = bus.node_v[{winner, 2'b00} +: 4];
               gnt_d          = '0;
               gnt_d[winner]  = 1'b1;
               state_d        = S_GRANT;
            end
         end
         S_GRANT: begin
            tally_en = 1'b1;
            state_d  = S_WAIT_REL;
         end
         S_WAIT_REL: begin
            if (!bus.req[owner_q]) begin
               gnt_d   = '0;
               ptr_d   = (owner_q == PTR_W'(NUM_NODES - 1)) ? '0 : owner_q + 1'b1;
               state_d = S_IDLE;
            end
         end
         S_CLOSED: gnt_d = '0;
         default: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign parity_bad = vote_q[3] ^ (^vote_q[2:0]);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         vote_q    <= '0;
         gnt_q     <= '0;
         done_q    <= 1'b0;
         green_cnt <= '0;
         red_cnt   <= '0;
         blank_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         vote_q  <= vote_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         if (tally_en) begin
            if (parity_bad) begin
               err_cnt <= sat_inc(err_cnt);
            end else if (!vote_q[0]) begin
               blank_cnt <= sat_inc(blank_cnt);
            end else begin
               if (vote_q[1]) green_cnt <= sat_inc(green_cnt);
               if (vote_q[2]) red_cnt   <= sat_inc(red_cnt);
            end
         end
      end
   end

   assign bus.gnt = gnt_q;
   assign busy    = (state_q == S_GRANT) || (state_q == S_WAIT_REL);
   assign closed  = (state_q == S_CLOSED);
   assign done    = done_q;
endmodule

// File: tb/tb_vote_bus_arbiter.sv
module tb_vote_bus_arbiter;
   localparam int N = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic close_poll = 1'b0;
   always #5 clock = ~clock;

   vote_bus_arbiter_if #(.NUM_NODES(N)) bif ();
   vote_bus_arbiter_if #(.NUM_NODES(N)) sif ();
   assign sif.req    = bif.req;
   assign sif.node_v = bif.node_v;

   logic       busy, closed, done;
   logic [7:0] green_cnt, red_cnt, blank_cnt, err_cnt;
   logic       s_busy, s_closed, s_done;
   logic [1:0] s_green, s_red, s_blank, s_err;

   vote_bus_arbiter #(.NUM_NODES(N), .COUNT_W(8)) dut (
      .clock(clock), .reset(reset), .bus(bif.slave), .close_poll(close_poll),
      .busy(busy), .closed(closed), .done(done),
      .green_cnt(green_cnt), .red_cnt(red_cnt), .blank_cnt(blank_cnt), .err_cnt(err_cnt));

   // Same stimulus, 2-bit counters: exercises saturation.
   vote_bus_arbiter #(.NUM_NODES(N), .COUNT_W(2)) dut_sat (
      .clock(clock), .reset(reset), .bus(sif.slave), .close_poll(close_poll),
      .busy(s_busy), .closed(s_closed), .done(s_done),
      .green_cnt(s_green), .red_cnt(s_red), .blank_cnt(s_blank), .err_cnt(s_err));

   int checks = 0;
   int failures = 0;

   // Reference model: owner index (-1 = none), cycles since grant, raw counts.
   int         m_owner, m_age, m_ptr;
   int         m_err, m_blank, m_green, m_red;
   bit         m_closed, m_done;
   logic [3:0] m_vote;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
      end
   endfunction

   function automatic int sat(input int c, input int mx);
      return (c > mx) ? mx : c;
   endfunction

   function automatic void model_tally(input logic [3:0] v);
      if (v[3] != (v[0] ^ v[1] ^ v[2])) m_err++;
      else if (!v[0]) m_blank++;
      else begin
         m_green += int'(v[1]);
         m_red   += int'(v[2]);
      end
   endfunction

   function automatic void model_edge();
      if (reset) begin
         m_owner = -1; m_age = 0; m_ptr = 0; m_closed = 0; m_done = 0;
         m_err = 0; m_blank = 0; m_green = 0; m_red = 0; m_vote = '0;
         return;
      end
      m_done = 0;
      if (m_closed) return;
      if (m_owner < 0) begin
         if (close_poll) begin
            m_closed = 1;
            m_done   = 1;
         end else if (bif.req != '0) begin
            for (int k = 0; k < N; k++) begin
               int i;
               i = (m_ptr + k) % N;
               if (bif.req[i]) begin
                  m_owner = i;
                  m_vote  = bif.node_v[4*i +: 4];
                  m_age   = 0;
                  break;
               end
            end
         end
      end else if (m_age == 0) begin
         model_tally(m_vote);
         m_age = 1;
      end else if (!bif.req[m_owner]) begin
         m_ptr   = (m_owner + 1) % N;
         m_owner = -1;
      end
   endfunction

   function automatic void compare_all();
      int eg;
      eg = (m_owner >= 0) ? (1 << m_owner) : 0;
      chk("gnt", int'(bif.gnt), eg);
      chk("sat_gnt", int'(sif.gnt), eg);
      chk("busy", int'(busy), int'(m_owner >= 0));
      chk("closed", int'(closed), int'(m_closed));
      chk("done", int'(done), int'(m_done));
      chk("green", int'(green_cnt), sat(m_green, 255));
      chk("red", int'(red_cnt), sat(m_red, 255));
      chk("blank", int'(blank_cnt), sat(m_blank, 255));
      chk("err", int'(err_cnt), sat(m_err, 255));
      chk("sat_green", int'(s_green), sat(m_green, 3));
      chk("sat_red", int'(s_red), sat(m_red, 3));
      chk("sat_blank", int'(s_blank), sat(m_blank, 3));
      chk("sat_err", int'(s_err), sat(m_err, 3));
   endfunction

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bif.req = '0;
      close_poll = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic vote_txn(input int node, input logic [3:0] v);
      bif.node_v[4*node +: 4] = v;
      bif.req[node] = 1'b1;
      step();
      step();
      bif.req[node] = 1'b0;
      step();
   endtask

   typedef struct {
      logic [3:0] v;
      int err, blank, green, red;
   } cls_vec_t;

   cls_vec_t tbl[9];
   int       order[$];
   int       exp_rr[6];
   int       hold[N];

   initial begin
      // Cumulative expected counts after each vote from node 0.
      tbl[0] = '{4'b1011, 1, 0, 0, 0};
      tbl[1] = '{4'b0000, 1, 1, 0, 0};
      tbl[2] = '{4'b1101, 2, 1, 0, 0};
      tbl[3] = '{4'b0101, 2, 1, 0, 1};
      tbl[4] = '{4'b0011, 2, 1, 1, 1};
      tbl[5] = '{4'b1111, 2, 1, 2, 2};
      tbl[6] = '{4'b1010, 2, 2, 2, 2};
      tbl[7] = '{4'b1001, 2, 2, 2, 2};
      tbl[8] = '{4'b0111, 3, 2, 2, 2};
      exp_rr = '{0, 1, 2, 3, 0, 1};

      bif.req = '0;
      bif.node_v = '0;

      // Reset state
      do_reset();
      step();
      chk("rst_gnt", int'(bif.gnt), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_closed", int'(closed), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_green", int'(green_cnt), 0);
      chk("rst_err", int'(err_cnt), 0);

      // Single vote, 1-cycle grant latency, tally 2 cycles after req
      do_reset();
      bif.node_v[7:4] = 4'b1111;
      bif.req = 4'b0010;
      step();
      chk("t1_gnt_lat", int'(bif.gnt), 2);
      chk("t1_green_early", int'(green_cnt), 0);
      step();
      chk("t1_green", int'(green_cnt), 1);
      chk("t1_red", int'(red_cnt), 1);
      chk("t1_blank", int'(blank_cnt), 0);
      chk("t1_err", int'(err_cnt), 0);
      step();
      step();
      chk("t1_gnt_hold", int'(bif.gnt), 2);
      bif.req = '0;
      step();
      chk("t1_gnt_rel", int'(bif.gnt), 0);

      // Round-robin fairness
      do_reset();
      bif.node_v = 16'h3333;
      bif.req = 4'hF;
      begin
         logic [N-1:0] prev_g;
         prev_g = '0;
         for (int c = 0; c < 60 && order.size() < 6; c++) begin
            step();
            if (bif.gnt != '0 && bif.gnt != prev_g)
               for (int i = 0; i < N; i++) if (bif.gnt[i]) order.push_back(i);
            prev_g = bif.gnt;
            for (int i = 0; i < N; i++) begin
               if (bif.gnt[i] && bif.req[i]) bif.req[i] = 1'b0;
               else if (!bif.gnt[i] && !bif.req[i]) bif.req[i] = 1'b1;
            end
         end
      end
      chk("rr_count", order.size(), 6);
      for (int j = 0; j < order.size() && j < 6; j++) chk("rr_order", order[j], exp_rr[j]);
      bif.req = '0;
      repeat (3) step();

      // Parity / blank classification table
      do_reset();
      for (int t = 0; t < 9; t++) begin
         vote_txn(0, tbl[t].v);
         chk("cls_err", int'(err_cnt), tbl[t].err);
         chk("cls_blank", int'(blank_cnt), tbl[t].blank);
         chk("cls_green", int'(green_cnt), tbl[t].green);
         chk("cls_red", int'(red_cnt), tbl[t].red);
      end

      // Saturation at 2^COUNT_W-1
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         vote_txn(1, 4'b0011);
         chk("sat_small_green", int'(s_green), (k > 3) ? 3 : k);
         chk("sat_main_green", int'(green_cnt), k);
      end

      // Close during a transaction
      do_reset();
      bif.node_v[11:8] = 4'b1111;
      bif.req = 4'b0100;
      step();
      chk("cl_gnt", int'(bif.gnt), 4);
      step();
      close_poll = 1'b1;
      step();
      chk("cl_gnt_hold", int'(bif.gnt), 4);
      chk("cl_not_closed", int'(closed), 0);
      bif.req = '0;
      step();
      chk("cl_rel_gnt", int'(bif.gnt), 0);
      chk("cl_tally", int'(green_cnt), 1);
      step();
      chk("cl_closed", int'(closed), 1);
      chk("cl_done", int'(done), 1);
      step();
      chk("cl_done_pulse", int'(done), 0);
      close_poll = 1'b0;
      bif.req = 4'hF;
      repeat (3) step();
      chk("cl_no_gnt", int'(bif.gnt), 0);
      chk("cl_no_busy", int'(busy), 0);
      chk("cl_hold_green", int'(green_cnt), 1);

      // Simultaneous req and close_poll in IDLE
      do_reset();
      bif.req = 4'b0001;
      close_poll = 1'b1;
      step();
      chk("sim_gnt", int'(bif.gnt), 0);
      chk("sim_closed", int'(closed), 1);
      chk("sim_done", int'(done), 1);
      close_poll = 1'b0;
      bif.req = '0;

      // Reset mid-transaction
      do_reset();
      bif.node_v = 16'hFFFF;
      bif.req = 4'b0100;
      step();
      step();
      chk("mr_gnt", int'(bif.gnt), 4);
      chk("mr_green", int'(green_cnt), 1);
      reset = 1'b1;
      step();
      chk("mr_rst_gnt", int'(bif.gnt), 0);
      chk("mr_rst_green", int'(green_cnt), 0);
      chk("mr_rst_busy", int'(busy), 0);
      reset = 1'b0;
      bif.req = 4'b0110;
      step();
      chk("mr_ptr0", int'(bif.gnt), 2);
      bif.req = '0;
      repeat (3) step();

      // Randomized protocol-following nodes against the model
      do_reset();
      for (int i = 0; i < N; i++) hold[i] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (bif.req[i]) begin
               if (bif.gnt[i]) begin
                  if (hold[i] == 0) bif.req[i] = 1'b0;
                  else hold[i]--;
               end
            end else if (!bif.gnt[i] && $urandom_range(0, 3) == 0) begin
               bif.node_v[4*i +: 4] = 4'($urandom);
               hold[i] = $urandom_range(0, 3);
               bif.req[i] = 1'b1;
            end
         end
         close_poll = ($urandom_range(0, 199) == 0);
         reset = ($urandom_range(0, 249) == 0);
         step();
      end
      reset = 1'b0;
      close_poll = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
